// File: rtl/wb_slave_stub.sv
// rtl/wb_slave_stub.sv - Wishbone B3 slave stub: error-only or register-file personality with wait states.
// Optional trace of every response/abort: define WB_SLAVE_STUB_TRACE_EN.
module wb_slave_stub #(
    parameter int                   ADR_WIDTH   = 24,
    parameter int                   DAT_WIDTH   = 32,
    parameter int                   REG_COUNT   = 16,
    parameter int                   WAIT_STATES = 0,
    parameter int                   MODE        = 1,
    parameter logic [DAT_WIDTH-1:0] ID_VALUE    = DAT_WIDTH'(32'h5354_0001)
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rstn_i,
    input  logic [ADR_WIDTH-1:0]   wb_adr_i,
    input  logic [DAT_WIDTH-1:0]   wb_dat_i,
    output logic [DAT_WIDTH-1:0]   wb_dat_o,
    input  logic [DAT_WIDTH/8-1:0] wb_sel_i,
    input  logic                   wb_we_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   int_o
);

    localparam int SEL_WIDTH = DAT_WIDTH / 8;
    localparam int IDX_W     = $clog2(REG_COUNT);
    // Address bits that may be set in a good access: the word index field only.
    localparam logic [ADR_WIDTH-1:0] IDX_MASK = ADR_WIDTH'(((1 << IDX_W) - 1) << 2);

    if (WAIT_STATES < 0 || WAIT_STATES > 255) begin : g_bad_wait_states
        $error("wb_slave_stub: WAIT_STATES=%0d outside 0..255", WAIT_STATES);
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [ADR_WIDTH-1:0]   adr_q;
    logic [DAT_WIDTH-1:0]   wdat_q;
    logic [SEL_WIDTH-1:0]   sel_q;
    logic                   we_q;
    logic                   ack_q, err_q, int_q;
    logic [DAT_WIDTH-1:0]   dat_q;
    logic [DAT_WIDTH-1:0]   regs_q [REG_COUNT];

    logic                   req;
    logic                   bad;
    logic [IDX_W-1:0]       idx;
    logic [DAT_WIDTH-1:0]   rd_word;
    logic                   ack_d, err_d, wr_en;
    logic [DAT_WIDTH-1:0]   dat_d;

    assign req     = wb_cyc_i & wb_stb_i;
    assign idx     = adr_q[IDX_W+1:2];
    assign bad     = (|(adr_q & ~IDX_MASK)) || (sel_q == '0) || (MODE == 0);
    assign rd_word = (idx == '0) ? ID_VALUE : regs_q[idx];

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = 8'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The response cycle decides ack/err; the outputs are registered from it.
    always_comb begin
        ack_d = (state_q == S_RESP) && !bad;
        err_d = (state_q == S_RESP) && bad;
        wr_en = ack_d && we_q && (idx != '0);
        dat_d = (ack_d && !we_q) ? rd_word : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            int_q  <= 1'b0;
            dat_q  <= '0;
            adr_q  <= '0;
            wdat_q <= '0;
            sel_q  <= '0;
            we_q   <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
            dat_q <= dat_d;
            int_q <= regs_q[REG_COUNT-1][0];
            if (state_q == S_IDLE && req) begin
                adr_q  <= wb_adr_i;
                wdat_q <= wb_dat_i;
                sel_q  <= wb_sel_i;
                we_q   <= wb_we_i;
            end
            if (wr_en) begin
                for (int b = 0; b < SEL_WIDTH; b++) begin
                    if (sel_q[b]) regs_q[idx][8*b +: 8] <= wdat_q[8*b +: 8];
                end
            end
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = dat_q;
    assign int_o    = int_q;

`ifdef WB_SLAVE_STUB_TRACE_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rstn_i) begin
            if (state_q == S_RESP)
                $display("%m %0t %s adr=%h dat=%h sel=%h %s", $time, we_q ? "W" : "R",
                         adr_q, we_q ? wdat_q : rd_word, sel_q, bad ? "ERR" : "ACK");
            else if (state_q == S_WAIT && !wb_cyc_i)
                $display("%m %0t ABORT adr=%h", $time, adr_q);
        end
    end
`endif

endmodule
